// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing one 4:1 mux among four requesters.
// Each grant ends on withdrawal or after MAX_HOLD beats; out is driven through a valid/ready port.
module mux4_rr_sched #(
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [DW-1:0] in0,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic [DW-1:0] in3,
  input  logic          out_ready,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic [DW-1:0] out,
  output logic          out_valid
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] hold_q, hold_d;

  logic          beat;
  logic          do_arb;
  logic [1:0]    pick_ptr;
  logic [2:0]    pick;
  logic [DW-1:0] mux_data;

  // Returns {found, index}; scanning downwards lets the lowest offset from p win.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign beat = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    do_arb   = 1'b0;
    pick_ptr = ptr_q;
    unique case (state_q)
      StIdle: do_arb = 1'b1;
      StGrant: begin
        if (!req[sel_q] || (beat && hold_q == CW'(MAX_HOLD - 1))) begin
          // Released owner moves to lowest priority for the same-edge re-arbitration.
          ptr_d    = sel_q + 2'd1;
          pick_ptr = sel_q + 2'd1;
          hold_d   = '0;
          do_arb   = 1'b1;
        end else if (beat) begin
          hold_d = hold_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    pick = rr_pick(req, pick_ptr);
    if (do_arb) begin
      if (pick[2]) begin
        state_d = StGrant;
        sel_d   = pick[1:0];
        gnt_d   = 4'b0001 << pick[1:0];
      end else begin
        state_d = StIdle;
        sel_d   = 2'd0;
        gnt_d   = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    mux_data = '0;
    unique case (sel_q)
      2'd0: mux_data = in0;
      2'd1: mux_data = in1;
      2'd2: mux_data = in2;
      2'd3: mux_data = in3;
      default: mux_data = '0;
    endcase
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign out       = (gnt_q != 4'b0000) ? mux_data : '0;
  assign out_valid = (gnt_q != 4'b0000) && req[sel_q];

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched with hand-computed expectations.
module tb_mux4_rr_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] in0, in1, in2, in3;
  logic       out_ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [7:0] out;
  logic       out_valid;

  int n_tests;
  int n_fail;

  mux4_rr_sched #(.DW(8), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Async reset pulse placed between clock edges.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_out", 32'(out), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] data_tab [4];
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b1;
    in0 = 8'h11; in1 = 8'h22; in2 = 8'hA5; in3 = 8'h44;
    data_tab[0] = 8'h11; data_tab[1] = 8'h22; data_tab[2] = 8'hA5; data_tab[3] = 8'h44;

    // 1: reset with requests pending
    #2;
    check("t1_gnt", 32'(gnt), 32'h0);
    check("t1_sel", 32'(sel), 32'h0);
    check("t1_out", 32'(out), 32'h0);
    check("t1_valid", 32'(out_valid), 32'h0);
    req = 4'b0100;
    #1 rst_n = 1'b1;

    // 2: sole requester, re-grant after 4 beats
    tick();
    check("t2_gnt", 32'(gnt), 32'h4);
    check("t2_sel", 32'(sel), 32'h2);
    check("t2_out", 32'(out), 32'hA5);
    check("t2_valid", 32'(out_valid), 32'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_hold_gnt", 32'(gnt), 32'h4);
    end
    check("t2_hold_cnt", 32'(dut.hold_q), 32'h0);

    // 3: all request, owners 0,1,2,3,0 for 4 cycles each
    pulse_reset();
    req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("t3_gnt", 32'(gnt), 32'(4'b0001 << ((k / 4) % 4)));
      check("t3_out", 32'(out), 32'(data_tab[(k / 4) % 4]));
    end

    // 4: backpressure freezes owner 1
    pulse_reset();
    req = 4'b0010;
    tick();
    check("t4_gnt", 32'(gnt), 32'h2);
    req = 4'b0011;
    tick();
    check("t4_hold1", 32'(dut.hold_q), 32'h1);
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t4_bp_gnt", 32'(gnt), 32'h2);
      check("t4_bp_valid", 32'(out_valid), 32'h1);
      check("t4_bp_hold", 32'(dut.hold_q), 32'h1);
    end
    out_ready = 1'b1;
    tick();
    check("t4_hold2", 32'(dut.hold_q), 32'h2);
    tick();
    check("t4_hold3", 32'(dut.hold_q), 32'h3);
    check("t4_still1", 32'(gnt), 32'h2);
    tick();
    check("t4_next_gnt", 32'(gnt), 32'h1);
    check("t4_next_hold", 32'(dut.hold_q), 32'h0);

    // 5: owner 1 withdraws after 2 beats
    pulse_reset();
    req = 4'b0010;
    tick();
    check("t5_gnt1", 32'(gnt), 32'h2);
    tick();
    tick();
    check("t5_hold2", 32'(dut.hold_q), 32'h2);
    req = 4'b1100;
    #1;
    check("t5_wd_valid", 32'(out_valid), 32'h0);
    tick();
    check("t5_gnt2", 32'(gnt), 32'h4);
    check("t5_hold0", 32'(dut.hold_q), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_gnt2_hold", 32'(gnt), 32'h4);
    end
    tick();
    check("t5_gnt3", 32'(gnt), 32'h8);

    // 6: reset mid-grant of owner 3
    pulse_reset();
    req = 4'b1111;
    for (int k = 0; k < 13; k++) tick();
    check("t6_owner3", 32'(gnt), 32'h8);
    tick();
    pulse_reset();
    tick();
    check("t6_gnt0", 32'(gnt), 32'h1);
    check("t6_sel0", 32'(sel), 32'h0);

    // Idle when nobody requests
    req = 4'b0000;
    tick();
    check("idle_gnt", 32'(gnt), 32'h0);
    check("idle_out", 32'(out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
